// File: rtl/query_proto_pkg.sv
// Shared definitions for the value-change word protocol: sentinel value,
// transmitter state encoding and frame length helper.
package query_proto_pkg;

    localparam logic [31:0] FRAME_SOF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        WORD,
        ESC,
        DONE
    } tx_state_t;

    function automatic int unsigned frame_len(input int unsigned dim);
        return dim + 2;
    endfunction

endpackage

// File: rtl/query_frame_tx.sv
// Serialises one query frame (DIM words, k, vertex id) onto a 32-bit
// value-change stream, inserting escape sentinels between equal neighbours.
module query_frame_tx
    import query_proto_pkg::*;
#(
    parameter int DIM         = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DIM-1:0][31:0]  query_in,
    input  logic [15:0]           k_in,
    input  logic [31:0]           vertex_id_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [31:0]           sig_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out
);

    localparam int unsigned          FLEN      = frame_len(DIM);
    localparam int unsigned          IDX_W     = $clog2(FLEN);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(FLEN - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
    localparam logic [15:0]          HOLD_LAST = 16'(HOLD_CYCLES - 1);

    tx_state_t          state_q, state_d;
    logic [15:0]        hold_q, hold_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        sig_q, sig_d;
    logic               err_q, err_d;
    logic [31:0]        frame_q [FLEN];
    logic [31:0]        frame_d [FLEN];

    logic [DIM-1:0]     q_is_sof;
    logic               frame_bad;
    logic               hold_end;
    logic [IDX_W-1:0]   idx_nxt;

    // A sentinel inside the payload would desynchronise the receiver.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_sof_chk
        assign q_is_sof[gi] = (query_in[gi] == FRAME_SOF);
    end

    assign frame_bad = (|q_is_sof) || (vertex_id_in == FRAME_SOF);
    assign hold_end  = (hold_q == HOLD_LAST);
    assign idx_nxt   = idx_q + IDX_ONE;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        sig_d   = sig_q;
        err_d   = 1'b0;
        frame_d = frame_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (valid_in) begin
                    if (frame_bad) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < DIM; i++) begin
                            frame_d[i] = query_in[i];
                        end
                        frame_d[DIM]   = {16'b0, k_in};
                        frame_d[DIM+1] = vertex_id_in;
                        state_d        = SOF;
                        sig_d          = FRAME_SOF;
                        hold_d         = 16'd0;
                        idx_d          = '0;
                    end
                end
            end

            SOF: begin
                if (hold_end) begin
                    hold_d  = 16'd0;
                    idx_d   = '0;
                    state_d = WORD;
                    sig_d   = frame_q[0];
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end

            WORD: begin
                if (hold_end) begin
                    hold_d = 16'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_nxt;
                        // Equal neighbours would be invisible to a change detector.
                        if (frame_q[idx_nxt] == frame_q[idx_q]) begin
                            state_d = ESC;
                            sig_d   = FRAME_SOF;
                        end else begin
                            sig_d = frame_q[idx_nxt];
                        end
                    end
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end

            ESC: begin
                if (hold_end) begin
                    hold_d  = 16'd0;
                    state_d = WORD;
                    sig_d   = frame_q[idx_q];
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            hold_q  <= 16'd0;
            idx_q   <= '0;
            sig_q   <= 32'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < FLEN; i++) begin
                frame_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            err_q   <= err_d;
            for (int i = 0; i < FLEN; i++) begin
                frame_q[i] <= frame_d[i];
            end
        end
    end

    assign ready_out = (state_q == IDLE) || (state_q == DONE);
    assign busy_out  = (state_q == SOF) || (state_q == WORD) || (state_q == ESC);
    assign done_out  = (state_q == DONE);
    assign error_out = err_q;
    assign sig_out   = sig_q;

endmodule

// File: tb/tb_query_frame_tx.sv
// Scoreboard bench: cycle-exact expectations for a HOLD=2 instance and a
// change-detecting loopback receiver on a HOLD=1 instance.
module tb_query_frame_tx;
    import query_proto_pkg::*;

    localparam int DIM    = 4;
    localparam int FLEN   = DIM + 2;
    localparam int HOLD_A = 2;
    localparam int HOLD_B = 1;

    typedef struct packed {
        logic [31:0] sig;
        logic        ready;
        logic        busy;
        logic        done;
        logic        err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DIM-1:0][31:0] query = '0;
    logic [15:0]          k     = '0;
    logic [31:0]          vid   = '0;
    logic                 valid_a = 1'b0;
    logic                 valid_b = 1'b0;

    logic [31:0] sig_a, sig_b;
    logic        ready_a, busy_a, done_a, err_a;
    logic        ready_b, busy_b, done_b, err_b;

    query_frame_tx #(.DIM(DIM), .HOLD_CYCLES(HOLD_A)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .query_in(query), .k_in(k),
        .vertex_id_in(vid), .valid_in(valid_a), .ready_out(ready_a),
        .sig_out(sig_a), .busy_out(busy_a), .done_out(done_a), .error_out(err_a)
    );

    query_frame_tx #(.DIM(DIM), .HOLD_CYCLES(HOLD_B)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .query_in(query), .k_in(k),
        .vertex_id_in(vid), .valid_in(valid_b), .ready_out(ready_b),
        .sig_out(sig_b), .busy_out(busy_b), .done_out(done_b), .error_out(err_b)
    );

    obs_t                 exp_q[$];
    logic [FLEN*32-1:0]   lb_q[$];
    int                   n_vec = 0;
    int                   n_err = 0;
    logic [31:0]          last_sig = 32'd0;

    task automatic chk(input string nm, input logic [FLEN*32-1:0] act, input logic [FLEN*32-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_n(input logic [31:0] s, input logic r, input logic b,
                                   input logic d, input logic e, input int n);
        obs_t o;
        o.sig = s; o.ready = r; o.busy = b; o.done = d; o.err = e;
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endfunction

    function automatic logic [DIM-1:0][31:0] mk_q(input logic [31:0] a, input logic [31:0] b,
                                                   input logic [31:0] c, input logic [31:0] d);
        logic [DIM-1:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // Monitor: one expected observation per cycle while the queue is non-empty.
    always @(negedge clk) begin
        obs_t o;
        if (rst_n && exp_q.size() > 0) begin
            o = exp_q.pop_front();
            chk("cycle_a", {sig_a, ready_a, busy_a, done_a, err_a}, o);
        end
    end

    // Loopback receiver: sentinel opens a frame, each non-sentinel change is a word.
    logic [31:0]            rx_prev = 32'd0;
    logic                   rx_in = 1'b0;
    int                     rx_cnt = 0;
    logic [FLEN*32-1:0]     rx_buf = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_prev = 32'd0;
            rx_in   = 1'b0;
            rx_cnt  = 0;
        end else if (sig_b != rx_prev) begin
            rx_prev = sig_b;
            if (sig_b == FRAME_SOF) begin
                if (!rx_in) begin
                    rx_in  = 1'b1;
                    rx_cnt = 0;
                end
            end else if (rx_in) begin
                rx_buf[rx_cnt*32 +: 32] = sig_b;
                rx_cnt++;
                if (rx_cnt == FLEN) begin
                    rx_in = 1'b0;
                    if (lb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL lb_unexpected: got %0h expected no frame", rx_buf);
                    end else begin
                        chk("loopback", rx_buf, lb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic start_a(input logic [DIM-1:0][31:0] qv, input logic [15:0] kv,
                           input logic [31:0] vv, input int extra);
        logic [31:0] w [FLEN];
        logic        bad;
        int          n_esc;
        @(negedge clk);
        query = qv; k = kv; vid = vv; valid_a = 1'b1;
        @(posedge clk);
        #1;
        bad = (vv == FRAME_SOF);
        for (int i = 0; i < DIM; i++) if (qv[i] == FRAME_SOF) bad = 1'b1;
        if (bad) begin
            push_n(last_sig, 1'b1, 1'b0, 1'b0, 1'b1, 1);
            push_n(last_sig, 1'b1, 1'b0, 1'b0, 1'b0, 1);
            $display("frame a: q=%h k=%0h vid=%0h expect reject", qv, kv, vv);
        end else begin
            for (int i = 0; i < DIM; i++) w[i] = qv[i];
            w[DIM]   = {16'b0, kv};
            w[DIM+1] = vv;
            n_esc = 0;
            push_n(FRAME_SOF, 1'b0, 1'b1, 1'b0, 1'b0, HOLD_A);
            for (int i = 0; i < FLEN; i++) begin
                if (i > 0 && w[i] == w[i-1]) begin
                    push_n(FRAME_SOF, 1'b0, 1'b1, 1'b0, 1'b0, HOLD_A);
                    n_esc++;
                end
                push_n(w[i], 1'b0, 1'b1, 1'b0, 1'b0, HOLD_A);
            end
            push_n(w[FLEN-1], 1'b1, 1'b0, 1'b1, 1'b0, 1);
            push_n(w[FLEN-1], 1'b1, 1'b0, 1'b0, 1'b0, 1);
            last_sig = w[FLEN-1];
            $display("frame a: q=%h k=%0h vid=%0h escapes=%0d", qv, kv, vv, n_esc);
        end
        if (extra > 0) begin
            repeat (extra) @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_a", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        chk("reset_state", {sig_a, ready_a, busy_a, done_a, err_a}, {32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        start_a(mk_q(5, 7, 1, 1), 16'd4, 32'd9, 0);
        drain_a();
        start_a(mk_q(1, 2, 3, 4), 16'd5, 32'd6, 0);
        drain_a();
        start_a(mk_q(1, 2, 3, 4), 16'd9, 32'd9, 0);
        drain_a();
        start_a(mk_q(1, 2, 32'hFFFF_FFFF, 4), 16'd5, 32'd6, 0);
        drain_a();
        start_a(mk_q(1, 2, 3, 4), 16'd5, 32'hFFFF_FFFF, 0);
        drain_a();
        start_a(mk_q(8, 8, 8, 8), 16'd1, 32'd2, 6);
        drain_a();

        // Reset in the middle of a frame abandons it.
        start_a(mk_q(10, 11, 12, 13), 16'd14, 32'd15, 0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst", {sig_a, ready_a, busy_a, done_a, err_a}, {32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        last_sig = 32'd0;
        start_a(mk_q(3, 1, 4, 1), 16'd5, 32'd9, 0);
        drain_a();

        for (int f = 0; f < 100; f++) begin
            logic [DIM-1:0][31:0] qv;
            logic [15:0]          kv;
            logic [31:0]          vv;
            logic [FLEN*32-1:0]   pk;
            int                   j;
            int                   guard;
            for (int i = 0; i < DIM; i++) qv[i] = $urandom_range(0, 3);
            kv = 16'($urandom_range(0, 3));
            vv = $urandom_range(0, 3);
            j  = $urandom_range(1, FLEN - 1);
            if (j < DIM)       qv[j] = qv[j-1];
            else if (j == DIM) kv    = qv[DIM-1][15:0];
            else               vv    = {16'b0, kv};
            guard = 0;
            while (!ready_b && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ready_b) chk("ready_b_timeout", ready_b, 1);
            @(negedge clk);
            query = qv; k = kv; vid = vv; valid_b = 1'b1;
            @(posedge clk);
            #1;
            valid_b = 1'b0;
            for (int i = 0; i < DIM; i++) pk[i*32 +: 32] = qv[i];
            pk[DIM*32 +: 32]     = {16'b0, kv};
            pk[(DIM+1)*32 +: 32] = vv;
            lb_q.push_back(pk);
            $display("loopback frame %0d sent %h", f, pk);
        end
        for (int i = 0; i < 200 && lb_q.size() != 0; i++) @(posedge clk);
        chk("lb_drain", lb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/query_frame_tx.md
Name: query_frame_tx

Overview:
- Transmit side of the value-change word protocol that the bfis top level consumes on its 32-bit sig_in register.
- Accepts one query frame in parallel (DIM query words, k, vertex id) and serialises it onto sig_out.
- Wire format: 32'hFFFFFFFF start sentinel, then DIM+2 data words. Each value is held HOLD_CYCLES cycles.
- Inserts an escape sentinel wherever two consecutive words are equal, so a change-detecting receiver captures every word. Used for on-chip loopback/self-test and for chaining query producers.

Parameters:
- DIM, 4, number of 32-bit query words per frame.
- HOLD_CYCLES, 4, cycles each emitted value is held on sig_out (legal range 1..65535).

Ports:
- clk_in  input  1  single clock for the whole block.
- rst_in  input  1  asynchronous, active-low reset.
- query_in  input  32 x DIM  query vector, sampled on accept.
- k_in  input  16  top-k count, sampled on accept, sent zero-extended to 32 bits.
- vertex_id_in  input  32  start vertex id, sampled on accept.
- valid_in  input  1  frame request.
- ready_out  output  1  high when idle and able to accept.
- sig_out  output  32  serial word stream.
- busy_out  output  1  high while a frame is being emitted.
- done_out  output  1  one-cycle pulse when the frame completes.
- error_out  output  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset (rst_in low, async):
  - sig_out=0, ready_out=1, busy_out=0, done_out=0, error_out=0.
  - State=IDLE, hold counter=0, word index=0.
  - A reset mid-frame abandons the frame immediately; there is no partial completion.
- Accept:
  - A frame is accepted on a rising edge where valid_in=1 and ready_out=1.
  - On accept, all DIM+2 words are registered into a frame buffer: word i=query_in[i] for i<DIM, word DIM={16'b0,k_in}, word DIM+1=vertex_id_in.
  - valid_in while busy is ignored; no queueing.
- Validation (same edge as accept):
  - If any query word or vertex_id_in equals 32'hFFFFFFFF, the frame is rejected.
  - On reject: error_out=1 for the next cycle, state stays IDLE, sig_out unchanged, ready_out stays 1.
- State machine: IDLE -> SOF -> WORD -> (ESC -> WORD)* -> DONE -> IDLE.
  - SOF: sig_out=32'hFFFFFFFF for HOLD_CYCLES, starting the cycle after accept.
  - WORD: sig_out=word[idx] for HOLD_CYCLES.
  - Escape rule: before emitting word[idx] (idx>=1), if word[idx]==word[idx-1], enter ESC first. ESC drives 32'hFFFFFFFF for HOLD_CYCLES, then goes to WORD. word[0] never needs an escape because it is never equal to 0xFFFFFFFF.
  - After word[DIM+1] has been held for its full HOLD_CYCLES, go to DONE for one cycle: done_out=1, busy_out=0, ready_out=1. A new frame may be accepted in that cycle. Then go to IDLE.
- busy_out=1 and ready_out=0 in SOF, WORD and ESC.
- sig_out keeps the last data word through DONE and IDLE until the next SOF.
- Timing: accept at edge T. Emission occupies cycles T+1 .. T+HOLD_CYCLES*(1+(DIM+2)+n_esc). done_out is high in the following cycle.
- Hold counter width: 16 bits. Word index width: $clog2(DIM+2).

Decomposition:
- Shared package query_proto_pkg:
  - localparam FRAME_SOF=32'hFFFFFFFF.
  - Typedef tx_state_t {IDLE,SOF,WORD,ESC,DONE}.
  - Function frame_len(DIM)=DIM+2.
- No sub-module. Hold timer, frame buffer and FSM are inline.

Test Plan (DIM=4, HOLD_CYCLES=2 unless stated):
- Escape insertion: query={5,7,1,1}, k=4, vid=9, accept at T -> sig_out per 2-cycle slot: FFFFFFFF,5,7,1,FFFFFFFF,1,4,9 over T+1..T+16. done_out pulses at T+17; ready_out is low for T+1..T+16.
- No-escape frame: query={1,2,3,4}, k=5, vid=6 -> 7 slots, 14 cycles, done_out at T+15.
- k/vid collision: query={1,2,3,4}, k=9, vid=9 -> ESC inserted between the two 9 words; 8 slots.
- Reject: query[2]=FFFFFFFF -> error_out=1 at T+1 only, sig_out unchanged, busy_out stays 0, a following valid frame is accepted normally. Also assert valid_in held during busy -> ignored, exactly one frame is emitted.
- Async reset: pull rst_in low at T+5 of a frame -> sig_out=0, ready_out=1 the same cycle. After release, a new frame emits from SOF.
- Loopback: connect sig_out to a change-detecting receiver model (latch on sentinel, capture each change that is not the sentinel), HOLD_CYCLES=1, 100 random frames with forced adjacent duplicates -> captured DIM+2 words equal the sent words on every frame.
